// File: rtl/mac_mul_sched_pkg.sv
// rtl/mac_mul_sched_pkg.sv - shared cfg/state encodings and pass-count helper for mac_mul_sched
package mac_mul_sched_pkg;

    localparam int MAC_MIN_WIDTH = 8;

    typedef enum logic [1:0] {
        CFG_SINGLE  = 2'd0,
        CFG_DUAL    = 2'd1,
        CFG_QUAD    = 2'd2,
        CFG_INVALID = 2'd3
    } cfg_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of B slices the multiplier must be run over for a given mode.
    function automatic logic [2:0] pass_count(input cfg_e cfg);
        case (cfg)
            CFG_SINGLE: return 3'd1;
            CFG_DUAL:   return 3'd2;
            CFG_QUAD:   return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mac_mul_sched_if.sv
// rtl/mac_mul_sched_if.sv - request/result/multiplier bus for mac_mul_sched (res_err with MAC_SCHED_ERR_EN)
interface mac_mul_sched_if #(
    parameter int MIN_W = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*4*MIN_W-1:0] req_a;
    logic [NREQ*4*MIN_W-1:0] req_b;
    logic [NREQ*2-1:0]       req_cfg;
    logic                    res_valid;
    logic                    res_ready;
    logic [8*MIN_W-1:0]      res_data;
    logic [1:0]              res_id;
    logic                    busy;
    logic [MIN_W-1:0]        mul_a0;
    logic [MIN_W-1:0]        mul_a1;
    logic [MIN_W-1:0]        mul_a2;
    logic [MIN_W-1:0]        mul_a3;
    logic [MIN_W-1:0]        mul_b2;
    logic [1:0]              mul_cfg;
    logic [5*MIN_W-1:0]      mul_c;
`ifdef MAC_SCHED_ERR_EN
    logic                    res_err;
`endif

    modport slave (
        input  req_valid, req_a, req_b, req_cfg, res_ready, mul_c,
        output req_ready, res_valid, res_data, res_id, busy,
        output mul_a0, mul_a1, mul_a2, mul_a3, mul_b2, mul_cfg
`ifdef MAC_SCHED_ERR_EN
        , output res_err
`endif
    );

    modport master (
        output req_valid, req_a, req_b, req_cfg, res_ready, mul_c,
        input  req_ready, res_valid, res_data, res_id, busy,
        input  mul_a0, mul_a1, mul_a2, mul_a3, mul_b2, mul_cfg
`ifdef MAC_SCHED_ERR_EN
        , input res_err
`endif
    );

endinterface

// File: rtl/mac_mul_sched_rr_arb.sv
// rtl/mac_mul_sched_rr_arb.sv - NREQ-wide round-robin arbiter (mac_rr_arb)
module mac_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [1:0]      o_idx,
    output logic            o_any
);

    logic [2:0] w_pos;

    // Scan from the pointer upward, wrapping, and take the first requester seen.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pos = {1'b0, i_ptr} + 3'(i);
            if (w_pos >= 3'(NREQ)) w_pos = w_pos - 3'(NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!o_any && (w_pos == 3'(j)) && i_req[j]) begin
                    o_any      = 1'b1;
                    o_idx      = 2'(j);
                    o_grant[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mac_mul_sched.sv
// rtl/mac_mul_sched.sv - round-robin job sequencer for a shared slice multiplier (res_err with MAC_SCHED_ERR_EN)
module mac_mul_sched
    import mac_mul_sched_pkg::*;
#(
    parameter int MIN_W = MAC_MIN_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic           clk,
    input  logic           rst,
    mac_mul_sched_if.slave bus
);

    localparam int AW = 4 * MIN_W;
    localparam int RW = 8 * MIN_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [1:0]        r_ptr;
    logic [1:0]        r_id;
    logic [1:0]        r_k;
    logic [AW-1:0]     r_a;
    logic [AW-1:0]     r_b;
    cfg_e              r_cfg;
    logic [RW-1:0]     r_acc;

    logic [NREQ-1:0]   w_grant;
    logic [1:0]        w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_last;
    logic [AW-1:0]     w_sel_a;
    logic [AW-1:0]     w_sel_b;
    cfg_e              w_sel_cfg;
    logic [MIN_W-1:0]  w_b_byte;
    logic [RW-1:0]     w_pp;

    mac_rr_arb #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cfg = CFG_SINGLE;
        for (int j = 0; j < NREQ; j++) begin
            if (w_idx == 2'(j)) begin
                w_sel_a   = bus.req_a[j*AW +: AW];
                w_sel_b   = bus.req_b[j*AW +: AW];
                w_sel_cfg = cfg_e'(bus.req_cfg[j*2 +: 2]);
            end
        end
    end

    always_comb begin
        w_b_byte = '0;
        for (int j = 0; j < 4; j++) begin
            if (r_k == 2'(j)) w_b_byte = r_b[j*MIN_W +: MIN_W];
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_any;
    assign w_last   = ({1'b0, r_k} == (pass_count(r_cfg) - 3'd1));
    // Partial product for slice k lands k bytes up in the accumulator.
    assign w_pp     = RW'(bus.mul_c) << (r_k * MIN_W);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = (w_sel_cfg == CFG_INVALID) ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.res_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cfg   <= CFG_SINGLE;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_cfg <= w_sel_cfg;
                r_id  <= w_idx;
                r_acc <= '0;
                r_k   <= '0;
                r_ptr <= (w_idx == 2'(NREQ - 1)) ? 2'd0 : w_idx + 2'd1;
            end else if (r_state == ST_RUN) begin
                r_acc <= r_acc + w_pp;
                r_k   <= r_k + 2'd1;
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.res_data  = (r_state == ST_DONE) ? r_acc : '0;
    assign bus.res_id    = (r_state == ST_DONE) ? r_id : 2'd0;
`ifdef MAC_SCHED_ERR_EN
    assign bus.res_err   = (r_state == ST_DONE) && (r_cfg == CFG_INVALID);
`endif

    // SINGLE/DUAL ride the upper lanes so the multiplier keeps one alignment for narrow modes.
    always_comb begin
        bus.mul_a0  = '0;
        bus.mul_a1  = '0;
        bus.mul_a2  = '0;
        bus.mul_a3  = '0;
        bus.mul_b2  = '0;
        bus.mul_cfg = '0;
        if (r_state == ST_RUN) begin
            bus.mul_cfg = r_cfg;
            bus.mul_b2  = w_b_byte;
            case (r_cfg)
                CFG_SINGLE: bus.mul_a2 = r_a[0 +: MIN_W];
                CFG_DUAL: begin
                    bus.mul_a2 = r_a[0 +: MIN_W];
                    bus.mul_a3 = r_a[MIN_W +: MIN_W];
                end
                CFG_QUAD: begin
                    bus.mul_a0 = r_a[0 +: MIN_W];
                    bus.mul_a1 = r_a[MIN_W +: MIN_W];
                    bus.mul_a2 = r_a[2*MIN_W +: MIN_W];
                    bus.mul_a3 = r_a[3*MIN_W +: MIN_W];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_mul_sched.sv
// tb/tb_mac_mul_sched.sv - randomized self-checking bench for mac_mul_sched
module tb_mac_mul_sched;

    localparam int MIN_W = 8;
    localparam int NREQ  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_mul_sched_if #(.MIN_W(MIN_W), .NREQ(NREQ)) bus();

    mac_mul_sched #(.MIN_W(MIN_W), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier behaviour: lanes form one operand per mode, times the B slice.
    always_comb begin
        case (bus.mul_cfg)
            2'd0:    bus.mul_c = 40'(bus.mul_a2) * 40'(bus.mul_b2);
            2'd1:    bus.mul_c = 40'({bus.mul_a3, bus.mul_a2}) * 40'(bus.mul_b2);
            2'd2:    bus.mul_c = 40'({bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0}) * 40'(bus.mul_b2);
            default: bus.mul_c = '0;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ptr = 0;
    logic [31:0] fa [NREQ];
    logic [31:0] fb [NREQ];
    logic [1:0]  fc [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'd0:    return 64'(a[7:0]) * 64'(b[7:0]);
            2'd1:    return 64'(a[15:0]) * 64'(b[15:0]);
            2'd2:    return 64'(a) * 64'(b);
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] c);
        case (c)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [1:0] c, input logic [31:0] a);
        case (c)
            2'd0:    return {8'h00, a[7:0], 16'h0000};
            2'd1:    return {a[15:8], a[7:0], 16'h0000};
            2'd2:    return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_data"},  bus.res_data, 64'd0);
        check({tag, "_res_id"},    64'(bus.res_id), 64'd0);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
        check({tag, "_mul_lanes"}, 64'({bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0}), 64'd0);
        check({tag, "_mul_b2"},    64'(bus.mul_b2), 64'd0);
        check({tag, "_mul_cfg"},   64'(bus.mul_cfg), 64'd0);
`ifdef MAC_SCHED_ERR_EN
        check({tag, "_res_err"},   64'(bus.res_err), 64'd0);
`endif
    endtask

    task automatic drive_req(input logic [NREQ-1:0] m);
        for (int r = 0; r < NREQ; r++) begin
            bus.req_a[r*32 +: 32] = fa[r];
            bus.req_b[r*32 +: 32] = fb[r];
            bus.req_cfg[r*2 +: 2] = fc[r];
        end
        bus.req_valid = m;
    endtask

    task automatic run_job(input logic [NREQ-1:0] m, input int hold);
        int g;
        int lat;
        int cyc;
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expd;
        logic [7:0]  bseq [$];
        logic [7:0]  v;
        logic [31:0] ln0;
        logic [1:0]  mc0;
        ln0 = '0;
        mc0 = '0;
        @(negedge clk);
        drive_req(m);
        g    = ref_pick(m, exp_ptr);
        c    = fc[g];
        a    = fa[g];
        b    = fb[g];
        lat  = ref_latency(c);
        expd = ref_prod(c, a, b);
        #1 check("req_ready", 64'(bus.req_ready), 64'(1 << g));
        @(posedge clk);
        exp_ptr = (g + 1) % NREQ;
        #1;
        bus.req_valid = '0;
        bus.req_a     = {$urandom, $urandom};
        bus.req_b     = {$urandom, $urandom};
        bus.req_cfg   = 4'($urandom);
        for (cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.res_valid) break;
            if (cyc == 0) begin
                ln0 = {bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0};
                mc0 = bus.mul_cfg;
            end
            bseq.push_back(bus.mul_b2);
        end
        check("latency", 64'(cyc), 64'(lat));
        check("res_data", bus.res_data, expd);
        check("res_id", 64'(bus.res_id), 64'(g));
`ifdef MAC_SCHED_ERR_EN
        check("res_err", 64'(bus.res_err), 64'(c == 2'd3));
`endif
        if (lat > 0) begin
            check("mul_lanes", 64'(ln0), 64'(ref_lanes(c, a)));
            check("mul_cfg", 64'(mc0), 64'(c));
        end
        for (int k = 0; k < lat; k++) begin
            v = (k < bseq.size()) ? bseq[k] : 8'hxx;
            check("mul_b2", 64'(v), 64'(b[k*8 +: 8]));
        end
        repeat (hold) begin
            bus.req_valid = '1;
            @(negedge clk);
            check("hold_valid", 64'(bus.res_valid), 64'd1);
            check("hold_data", bus.res_data, expd);
            check("hold_id", 64'(bus.res_id), 64'(g));
            check("hold_no_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_drop", 64'(bus.res_valid), 64'd0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cfg   = '0;
        bus.res_ready = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            fa[r] = '0;
            fb[r] = '0;
            fc[r] = '0;
        end
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        fa[0] = 32'h0000_00FF; fb[0] = 32'h0000_00FF; fc[0] = 2'd0;
        run_job(2'b01, 0);
        fa[0] = 32'h0000_1234; fb[0] = 32'h0000_5678; fc[0] = 2'd1;
        run_job(2'b01, 0);
        fa[0] = 32'hFFFF_FFFF; fb[0] = 32'hFFFF_FFFF; fc[0] = 2'd2;
        run_job(2'b01, 0);

        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                fa[r] = $urandom; fb[r] = $urandom; fc[r] = 2'd0;
            end
            run_job(2'b11, 0);
        end

        fa[1] = $urandom; fb[1] = $urandom; fc[1] = 2'd2;
        run_job(2'b10, 10);
        fa[0] = $urandom; fb[0] = $urandom; fc[0] = 2'd3;
        run_job(2'b01, 2);

        fa[0] = 32'hFFFF_FFFF; fb[0] = 32'hFFFF_FFFF; fc[0] = 2'd2;
        @(negedge clk);
        drive_req(2'b01);
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midrun_rst");
        exp_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_valid", 64'(bus.res_valid), 64'd0);
        end
        for (int r = 0; r < NREQ; r++) begin
            fa[r] = $urandom; fb[r] = $urandom; fc[r] = 2'd0;
        end
        run_job(2'b11, 0);

        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                fa[r] = $urandom;
                fb[r] = $urandom;
                fc[r] = 2'($urandom_range(0, 3));
            end
            run_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_mul_sched.md
Name: mac_mul_sched

Overview:
- Sequencer and arbiter for one shared quad-capable 8-bit-slice multiply block.
- Accepts multiply jobs from NREQ requesters and grants them round-robin.
- Runs the multiplier over one B slice per cycle and shift-accumulates the partial products into a full-width result.
- Sits between the MAC lane front-ends and the multiply datapath; owns the multiplier's operand, B-slice and cfg inputs.

Parameters:
- MIN_W, 8, slice width (matches MAC_MIN_WIDTH).
- NREQ, 2, number of requesters (2..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  job request, one bit per requester.
- req_ready  out  NREQ  one-hot grant; a job is accepted when valid&ready.
- req_a  in  NREQ*4*MIN_W  A operand per requester.
- req_b  in  NREQ*4*MIN_W  B operand per requester.
- req_cfg  in  NREQ*2  per requester: 0=SINGLE, 1=DUAL, 2=QUAD, 3=invalid.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_data  out  8*MIN_W  product.
- res_id  out  2  index of the granted requester.
- busy  out  1  high in any state other than IDLE.
- mul_a0..mul_a3  out  MIN_W each  multiplier A lanes.
- mul_b2  out  MIN_W  multiplier B slice.
- mul_cfg  out  2  multiplier mode.
- mul_c  in  5*MIN_W  combinational multiplier result.

Behaviour:
- Reset (rst=0, async): state=IDLE, RR pointer=0, acc=0, k=0. All outputs are 0: req_ready, res_valid, res_data, res_id, busy, mul_*.
- FSM states: IDLE, RUN, DONE.
- IDLE arbitration:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping around.
  - req_ready is asserted combinationally that cycle, only in IDLE, for the granted bit only.
  - On accept: latch A, B, cfg and id; acc=0, k=0; pointer=grant+1 (mod NREQ); go to RUN.
  - If no req_valid is set, stay in IDLE.
- Pass count P: SINGLE=1, DUAL=2, QUAD=4.
- Lane mapping (A byte j = A[j*MIN_W +: MIN_W]):
  - SINGLE: byte0→a2.
  - DUAL: byte0→a2, byte1→a3.
  - QUAD: byte0..3→a0..a3.
  - Unused lanes are driven 0. mul_cfg = latched cfg while in RUN, else 0.
- RUN:
  - mul_b2 = B byte k.
  - Each cycle: acc += zext(mul_c) << (k*MIN_W), then k++.
  - When k==P-1, perform the final add and go to DONE.
  - acc is 8*MIN_W wide; the full product always fits, so there is no overflow.
  - SINGLE/DUAL results occupy the low 2*MIN_W / 4*MIN_W bits; upper bits are 0.
- DONE:
  - res_valid=1, res_data=acc, res_id=latched id.
  - These are held stable until res_ready.
  - On handshake, go to IDLE with res_valid=0 the next cycle.
- Latency: accept edge → res_valid after P cycles (SINGLE 1, DUAL 2, QUAD 4). Minimum job spacing is P+2 cycles.
- Invalid cfg (3): skip RUN; go IDLE→DONE with acc=0.
- req_valid dropping while RUN/DONE has no effect. Job inputs are sampled only at accept.
- Reset mid-RUN or mid-DONE: the job is discarded, no res_valid is produced, and the pointer returns to 0.
- Simultaneous requests: exactly one grant per accept. A requester is never granted twice in a row while another is requesting.

Optional Feature:
- Macro MAC_SCHED_ERR_EN.
- Defined: adds output port res_err (1 bit, reset 0). It is set with res_valid in DONE when the latched cfg==3, and is 0 for valid cfgs.
- Undefined: no res_err port. An invalid cfg still returns res_data=0 silently.

Decomposition:
- Shared package/header (extends mac_const): cfg encodings SINGLE/DUAL/QUAD/INVALID, FSM state encoding, pass-count function cfg→P.
- One sub-module: mac_rr_arb (NREQ-wide round-robin arbiter; inputs req and pointer, output one-hot grant plus encoded index).
- The multiplier is instantiated outside this block.

Test Plan:
- SINGLE, A=0xFF, B=0xFF, req0 → res_data=0xFE01, res_id=0, res_valid 1 cycle after accept.
- DUAL, A=0x1234, B=0x5678 → res_data=0x06260060 after 2 RUN cycles; mul_b2 sequence 0x78, 0x56.
- QUAD, A=B=0xFFFFFFFF → res_data=0xFFFFFFFE00000001 after 4 cycles; mul_b2 sequence FF×4; lanes a0..a3 all FF.
- req0 and req1 both held valid with SINGLE jobs → grants alternate 0,1,0,1; res_id matches each grant.
- res_ready held low 10 cycles in DONE → res_valid and res_data stable; no new req_ready during the wait.
- Reset asserted during RUN of a QUAD job → all outputs 0 immediately; after release, a SINGLE job completes normally. With MAC_SCHED_ERR_EN, cfg=3 → res_data=0, res_err=1.
